// File: rtl/audio_mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM master between a record port (0)
// and a playback port (1). An in-order tag FIFO routes each returning read word to its issuer.
module audio_mem_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_readdatavalid,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_readdatavalid,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic              err_orphan
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state;
    logic               last;
    logic               grant;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               tag_mem [MAX_OUT];

    logic full, elig0, elig1, pick, accept, push, pop, head;

    assign full   = (count == CNT_W'(MAX_OUT));
    // A write is always eligible; a write with read also high is treated as a pure write.
    assign elig0  = r0_write | (r0_read & ~full);
    assign elig1  = r1_write | (r1_read & ~full);
    assign pick   = (elig0 & elig1) ? ~last : elig1;
    assign accept = (state == ISSUE) & ~m_waitrequest;
    assign push   = accept & m_read;
    assign pop    = m_readdatavalid & (count != '0);
    assign head   = tag_mem[rd_ptr];

    assign r0_waitrequest = ~(accept & ~grant);
    assign r1_waitrequest = ~(accept & grant);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            grant       <= 1'b0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        state       <= ISSUE;
                        grant       <= pick;
                        m_write     <= pick ? r1_write : r0_write;
                        m_read      <= pick ? (r1_read & ~r1_write) : (r0_read & ~r0_write);
                        m_address   <= pick ? r1_address : r0_address;
                        m_writedata <= pick ? r1_writedata : r0_writedata;
                    end
                end
                ISSUE: begin
                    if (!m_waitrequest) begin
                        state   <= IDLE;
                        last    <= grant;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: tag storage has no reset; an entry is only read after it was written, and the pointers/count are reset.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r0_readdata      <= '0;
            r1_readdata      <= '0;
            r0_readdatavalid <= 1'b0;
            r1_readdatavalid <= 1'b0;
            err_orphan       <= 1'b0;
        end else begin
            r0_readdatavalid <= pop & ~head;
            r1_readdatavalid <= pop & head;
            if (pop & ~head) r0_readdata <= m_readdata;
            if (pop & head)  r1_readdata <= m_readdata;
            // Sticky until reset: data arriving with no outstanding tag is dropped.
            err_orphan <= err_orphan | (m_readdatavalid & (count == '0));
        end
    end

endmodule

// File: doc/audio_mem_arbiter.md
# audio_mem_arbiter

Two-port arbiter that shares the single SDRAM Avalon-MM master port of the audio system between a record requester (port 0, e.g. codec sample write-back) and a playback/delay requester (port 1, e.g. delayed-sample fetch for `processor`). It grants access round-robin and holds each command through memory back-pressure. It also tracks outstanding reads in an in-order tag FIFO so that returning read data is routed to the requester that issued it. It sits between the audio datapath and the SDRAM controller, all in the `CLOCK_50` domain.

## Interface
- `ADDR_W`, 25: word address width of the requester and master ports.
- `DATA_W`, 16: sample/data width, matching the 16-bit audio path.
- `MAX_OUT`, 4: maximum outstanding reads (tag FIFO depth, power of 2, ≥2).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rN_read`, `rN_write` in 1 (N=0,1): Avalon-style command; held until accepted.
- `rN_address` in ADDR_W: command address.
- `rN_writedata` in DATA_W: write data.
- `rN_waitrequest` out 1: 1 = command not yet accepted.
- `rN_readdata` out DATA_W: returned read data.
- `rN_readdatavalid` out 1: one-cycle strobe qualifying `rN_readdata`.
- `m_read`, `m_write` out 1: master command to the SDRAM controller.
- `m_address` out ADDR_W: master address.
- `m_writedata` out DATA_W: master write data.
- `m_waitrequest` in 1: SDRAM back-pressure.
- `m_readdata` in DATA_W: SDRAM read data.
- `m_readdatavalid` in 1: SDRAM read-data strobe.
- `err_orphan` out 1: sticky flag, set when read data arrives while the tag FIFO is empty.

## Operation
- FSM states:
  - IDLE: evaluates eligible requests.
  - ISSUE: drives the granted command on `m_*` until `m_waitrequest`=0.
  - IDLE→ISSUE when any eligible request exists; ISSUE→IDLE on acceptance.
- Eligibility:
  - A write is always eligible.
  - A read is eligible only while the tag FIFO count < MAX_OUT.
- `rN_read` and `rN_write` both high is illegal. Write wins and the read is ignored for that command.
- Round-robin: a 1-bit `last` pointer records the most recent grant. When both ports are eligible, grant `!last`. A single eligible port is granted regardless of `last`.
- Grant is registered: `m_*` outputs are latched from the winning port on the IDLE→ISSUE edge and held stable throughout ISSUE.
- On acceptance in ISSUE (`m_waitrequest`=0):
  - `rN_waitrequest` of the granted port is 0 for exactly that cycle.
  - `last` updates.
  - For a read, the port id is pushed into the tag FIFO.
- Read return: on `m_readdatavalid`, pop the FIFO head id. Route `m_readdata` to that port, registered with 1-cycle latency.
- Push and pop in the same cycle: count unchanged. This is legal at any count, including full.
- `m_readdatavalid` with the FIFO empty: data is dropped, no `rN_readdatavalid` is raised, and `err_orphan` is set. `err_orphan` is cleared only by reset.
- The arbiter inserts no ordering between ports. The SDRAM controller returns data in order, which the FIFO relies on.

## Timing
- Reset values:
  - `m_read`=`m_write`=0, `m_address`=`m_writedata`=0.
  - `rN_waitrequest`=1, `rN_readdatavalid`=0, `rN_readdata`=0.
  - `err_orphan`=0, FIFO empty, `last`=1 (port 0 wins the first tie), FSM=IDLE.
- Best-case command latency is 2 cycles, request→acceptance: cycle 0 request seen in IDLE, cycle 1 `m_*` asserted and accepted. The cycle after acceptance is IDLE, so maximum throughput is one command per 2 cycles.
- Each `m_waitrequest`=1 cycle in ISSUE adds one cycle. `m_*` never change while stalled.
- `rN_readdatavalid` is asserted exactly 1 cycle after the corresponding `m_readdatavalid`.
- Reset mid-ISSUE: `m_*` drop asynchronously and the pending requester sees `rN_waitrequest`=1. In-flight read data arriving after reset hits an empty FIFO and sets `err_orphan`.
- A requester deasserting its command while `rN_waitrequest`=1 violates protocol. The latched command still completes.

## Test plan
- Single port-0 write, addr 0x10, data 0x1234, `m_waitrequest`=0 → `m_write`=1 with those values in cycle 1, `r0_waitrequest`=0 in cycle 1 only.
- Both ports read continuously, zero wait → grants alternate 0,1,0,1. Read data fed back in order returns 0xA000.. to r0 and 0xB000.. to r1 with correct order, 1-cycle latency.
- Port 1 read with `m_waitrequest` held high 5 cycles → `m_read`/`m_address` stable for 6 cycles, accepted on cycle 6, FIFO count becomes 1.
- MAX_OUT=4, five back-to-back port-0 reads with no data return → 4 accepted, 5th waits (`r0_waitrequest`=1). A concurrent port-1 write is still granted. One `m_readdatavalid` lets the 5th read issue.
- `m_readdatavalid` pulse with no reads outstanding, data 0xDEAD → no `rN_readdatavalid`, `err_orphan`=1 and stays 1 until `reset_n` low.
- Assert `reset_n`=0 during ISSUE of a port-0 write → `m_write`=0 immediately, all outputs at reset values; after release, the first tie goes to port 0.
